// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector with Mealy and Moore match flags.
// Watches a qualified serial bit stream for a PAT_W-bit PATTERN (MSB first),
// with optional overlapping matches. Define SEQ_DETECTOR_COUNT_EN to compile
// in the saturating match counter; otherwise match_count is tied to zero.
module seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clear,
  output logic             out_mealy,
  output logic             out_moore,
  output logic [CNT_W-1:0] match_count
);

  // The fill counter only needs to reach PAT_W-1, so clog2(PAT_W) bits suffice.
  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_W - 2);

  typedef enum logic {
    FILL,
    ARMED
  } state_t;

  state_t             state;
  logic [FILL_W-1:0]  fill;
  logic [PAT_W-2:0]   hist;
  logic [PAT_W-1:0]   window;
  logic               match;

  // The candidate pattern is the stored history with the current bit appended.
  assign window    = {hist, in};
  assign match     = in_valid && (state == ARMED) && (window == PATTERN) && !clear;
  assign out_mealy = match;

  // Shift history on each accepted bit, advance fill until armed, register the match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill      <= '0;
      hist      <= '0;
      out_moore <= 1'b0;
    end else if (clear) begin
      state     <= FILL;
      fill      <= '0;
      hist      <= '0;
      out_moore <= 1'b0;
    end else begin
      out_moore <= match;
      if (in_valid) begin
        hist <= window[PAT_W-2:0];
        if (match && (OVERLAP == 0)) begin
          fill  <= '0;
          state <= FILL;
        end else if (fill != FILL_MAX) begin
          fill  <= fill + 1'b1;
          state <= (fill == FILL_PRE) ? ARMED : FILL;
        end
      end
    end
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Count matches, saturating at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed bench for seq_detector.
// Three instances share one stimulus stream: default, non-overlapping, and a
// 2-bit counter. A reference model predicts each cycle's flags; registered
// results go through a queue and are compared after the clock edge.
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in;
  logic clear;

  logic       mealy_a, mealy_b, mealy_c;
  logic       moore_a, moore_b, moore_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic moore0;
    logic moore1;
    logic moore2;
    int   cnt0;
    int   cnt1;
    int   cnt2;
  } exp_t;

  exp_t exp_q[$];

  int m_hist [3];
  int m_fill [3];
  int m_cnt  [3];
  int ov     [3] = '{1, 0, 1};
  int cmax   [3] = '{255, 255, 3};

  seq_detector dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .clear(clear),
    .out_mealy(mealy_a), .out_moore(moore_a), .match_count(cnt_a)
  );

  seq_detector #(.OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .clear(clear),
    .out_mealy(mealy_b), .out_moore(moore_b), .match_count(cnt_b)
  );

  seq_detector #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .clear(clear),
    .out_mealy(mealy_c), .out_moore(moore_c), .match_count(cnt_c)
  );

  // 10 ns clock; rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic int cnt_exp(input int c);
`ifdef SEQ_DETECTOR_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] mealy_obs(input int k);
    case (k)
      0:       return {31'd0, mealy_a};
      1:       return {31'd0, mealy_b};
      default: return {31'd0, mealy_c};
    endcase
  endfunction

  function automatic logic [31:0] moore_obs(input int k);
    case (k)
      0:       return {31'd0, moore_a};
      1:       return {31'd0, moore_b};
      default: return {31'd0, moore_c};
    endcase
  endfunction

  function automatic logic [31:0] cnt_obs(input int k);
    case (k)
      0:       return {24'd0, cnt_a};
      1:       return {24'd0, cnt_b};
      default: return {30'd0, cnt_c};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = 0;
      m_fill[k] = 0;
      m_cnt[k]  = 0;
    end
  endtask

  // Every output of every instance must read zero.
  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s mealy%0d", tag, k), mealy_obs(k), 32'd0);
      check($sformatf("%s moore%0d", tag, k), moore_obs(k), 32'd0);
      check($sformatf("%s count%0d", tag, k), cnt_obs(k), 32'd0);
    end
  endtask

  // Pop the registered expectations for the edge just taken and compare.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s queue: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " moore0"}, moore_obs(0), {31'd0, e.moore0});
      check({tag, " moore1"}, moore_obs(1), {31'd0, e.moore1});
      check({tag, " moore2"}, moore_obs(2), {31'd0, e.moore2});
      check({tag, " count0"}, cnt_obs(0), 32'(cnt_exp(e.cnt0)));
      check({tag, " count1"}, cnt_obs(1), 32'(cnt_exp(e.cnt1)));
      check({tag, " count2"}, cnt_obs(2), 32'(cnt_exp(e.cnt2)));
    end
  endtask

  // Drive one cycle, check the combinational flag, predict the registered results.
  task automatic applyStimulus(input string tag, input logic v, input logic b, input logic c);
    logic m [3];
    int   win;
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in       = b;
    clear    = c;
    #1;
    for (int k = 0; k < 3; k++) begin
      win  = ((m_hist[k] << 1) | int'(b)) & 4'hF;
      m[k] = v && !c && (m_fill[k] == 3) && (win == 4'b1011);
      check($sformatf("%s mealy%0d", tag, k), mealy_obs(k), {31'd0, m[k]});
      if (c) begin
        m_hist[k] = 0;
        m_fill[k] = 0;
        m_cnt[k]  = 0;
      end else if (v) begin
        m_hist[k] = win & 7;
        if (m[k] && ov[k] == 0) m_fill[k] = 0;
        else if (m_fill[k] < 3) m_fill[k]++;
        if (m[k] && m_cnt[k] < cmax[k]) m_cnt[k]++;
      end
    end
    e.moore0 = m[0];
    e.moore1 = m[1];
    e.moore2 = m[2];
    e.cnt0   = m_cnt[0];
    e.cnt1   = m_cnt[1];
    e.cnt2   = m_cnt[2];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Send n accepted bits, MSB first.
  task automatic send_stream(input string tag, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(tag, 1'b1, bits[i], 1'b0);
    end
  endtask

  // Assert reset between clock edges and check outputs drop without a clock.
  task automatic reset_pulse(input string tag);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_all_zero(tag);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in       = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic 1011");
    send_stream("basic", 32'b1011, 4);
    applyStimulus("basic_idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] overlap stream 1011011");
    applyStimulus("clr1", 1'b0, 1'b0, 1'b1);
    send_stream("overlap", 32'b1011011, 7);

    $display("[TB] gaps inside a pattern");
    applyStimulus("clr2", 1'b0, 1'b0, 1'b1);
    applyStimulus("gap_b1", 1'b1, 1'b1, 1'b0);
    applyStimulus("gap_1", 1'b0, 1'b1, 1'b0);
    applyStimulus("gap_2", 1'b0, 1'b0, 1'b0);
    applyStimulus("gap_3", 1'b0, 1'b1, 1'b0);
    applyStimulus("gap_b2", 1'b1, 1'b0, 1'b0);
    applyStimulus("gap_b3", 1'b1, 1'b1, 1'b0);
    applyStimulus("gap_4", 1'b0, 1'b0, 1'b0);
    applyStimulus("gap_b4", 1'b1, 1'b1, 1'b0);
    applyStimulus("gap_5", 1'b0, 1'b0, 1'b0);

    $display("[TB] five back-to-back patterns");
    applyStimulus("clr3", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_stream($sformatf("b2b%0d", i), 32'b1011, 4);

    $display("[TB] clear mid-pattern");
    applyStimulus("clr4", 1'b0, 1'b0, 1'b1);
    send_stream("clrmid", 32'b10, 2);
    applyStimulus("clrmid_b3", 1'b1, 1'b1, 1'b1);
    send_stream("clrmid_tail", 32'b111, 3);

    $display("[TB] clear on the matching bit");
    applyStimulus("clr5", 1'b0, 1'b0, 1'b1);
    send_stream("clrhit", 32'b101, 3);
    applyStimulus("clrhit_b4", 1'b1, 1'b1, 1'b1);
    applyStimulus("clrhit_after", 1'b0, 1'b0, 1'b0);

    $display("[TB] reset between edges");
    send_stream("rst_pre", 32'b1011, 4);
    reset_pulse("rst_async");

    $display("[TB] reset mid-pattern");
    send_stream("rstmid", 32'b101, 3);
    reset_pulse("rst_mid");
    send_stream("rst_restart", 32'b1011, 4);
    applyStimulus("final_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Parameters
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, giving the PAT_W-bit target sequence, MSB received first.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 allows overlapping matches, 0 allows non-overlapping matches only.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the match counter width.

Interface
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  qualifies in; bit consumed only when high.
REQ-008 in  input  1  serial data bit.
REQ-009 clear  input  1  synchronous clear of all detector state.
REQ-010 out_mealy  output  1  combinational match flag, same cycle as the final pattern bit.
REQ-011 out_moore  output  1  registered match flag, one cycle after out_mealy.
REQ-012 match_count  output  CNT_W  number of matches since reset or clear.

Function
REQ-013 Internal state SHALL be hist (PAT_W-1 bits of most recent accepted bits) plus fill counter (0..PAT_W-1, saturating).
REQ-014 FSM states SHALL be FILL (fill < PAT_W-1) and ARMED (fill = PAT_W-1).
REQ-015 Transition rule: each accepted bit increments fill until ARMED; a match with OVERLAP=0 returns to FILL (fill <= 0).
REQ-016 Match M SHALL be defined as in_valid & ARMED & ({hist, in} == PATTERN) & !clear.
REQ-017 out_mealy SHALL equal M combinationally, with zero latency.
REQ-018 out_moore SHALL be registered M: high for exactly one cycle per match, in the cycle after the final bit.
REQ-019 While in_valid=0, hist, fill and match_count SHALL hold, and out_moore SHALL be 0 next cycle.
REQ-020 Idle in_valid gaps SHALL NOT break a partial pattern.
REQ-021 On every accepted bit, hist SHALL shift left by one and take in at the LSB, including on match cycles.
REQ-022 match_count SHALL increment by 1 on each M and saturate at 2^CNT_W-1 with no wrap.
REQ-023 clear SHALL take priority over in_valid and zero hist, fill, out_moore and match_count on the next edge.
REQ-024 A bit presented in the same cycle as clear SHALL be discarded.

Reset
REQ-025 Reset=1 SHALL immediately force hist=0, fill=0 (FILL state), out_moore=0 and match_count=0, without waiting for clk.
REQ-026 out_mealy SHALL be 0 while Reset is high, because ARMED is false.
REQ-027 Reset asserted mid-pattern SHALL discard the partial pattern; detection SHALL restart from an empty history.

Configuration
REQ-028 Macro SEQ_DETECTOR_COUNT_EN SHALL control whether the match counter is compiled in.
REQ-029 With SEQ_DETECTOR_COUNT_EN defined, match_count SHALL behave per REQ-022/023.
REQ-030 Without SEQ_DETECTOR_COUNT_EN, the counter register SHALL be absent and match_count SHALL be tied to 0.
REQ-031 The port list SHALL be identical with or without SEQ_DETECTOR_COUNT_EN.

Verification (default parameters unless stated, in_valid=1 unless stated)
REQ-032 Reset pulse, then in=1,0,1,1 -> out_mealy=1 during bit 4, out_moore=1 the next cycle only, match_count=1.
REQ-033 OVERLAP=1, stream 1,0,1,1,0,1,1 -> matches at bits 4 and 7, match_count=2; OVERLAP=0 with the same stream -> match at bit 4 only, match_count=1.
REQ-034 Stream 1,[in_valid=0 x3],0,1,[gap x1],1 -> single match on the last bit; out_moore=0 during all gaps.
REQ-035 CNT_W=2 (macro defined), 5 back-to-back 1011 patterns -> match_count sequence 1,2,3,3,3.
REQ-036 clear during bit 3 of 1,0,1,1, then 1,1 -> no match; Reset pulse asserted between clk edges -> outputs 0 immediately.
REQ-037 Rebuild without SEQ_DETECTOR_COUNT_EN, rerun REQ-032 -> identical out_mealy/out_moore, match_count=0 throughout.
